// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches words from RAM into ir for the decoder.
// Four-state FSM (IDLE/ADDR/READ/HOLD) with halt/branch redirect.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, halt         begin fetching from pc / return to IDLE
//   branch_valid/target redirect fetch to a new address
//   ir_ready            decoder accepts the held instruction
//   ir_valid, ir, pc    fetched instruction, its address
//   ram_*               RAM address, latch strobe, write, read enable, data
//   busy                high whenever not IDLE
module instruction_fetch_unit #(
  parameter int SIZE     = 16,
  parameter int MAR_SIZE = 8,
  parameter logic [MAR_SIZE-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                halt,
  input  logic                branch_valid,
  input  logic [MAR_SIZE-1:0] branch_target,
  input  logic                ir_ready,
  output logic                ir_valid,
  output logic [SIZE-1:0]     ir,
  output logic [MAR_SIZE-1:0] pc,
  output logic [MAR_SIZE-1:0] ram_address,
  output logic                ram_set_address,
  output logic                ram_set,
  output logic                ram_enable,
  input  logic [SIZE-1:0]     ram_data_out,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    READ,
    HOLD
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;

  assign accept = (state == HOLD) && ir_valid && ir_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (halt) begin
      state_nxt = IDLE;
    end else if (branch_valid) begin
      // From IDLE a branch only moves pc unless start comes with it.
      if (state == IDLE && !start) begin
        state_nxt = IDLE;
      end else begin
        state_nxt = ADDR;
      end
    end else begin
      unique case (state)
        IDLE: if (start) state_nxt = ADDR;
        ADDR: state_nxt = READ;
        READ: state_nxt = HOLD;
        HOLD: if (accept) state_nxt = ADDR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      ir       <= '0;
      ir_valid <= 1'b0;
    end else if (halt) begin
      ir_valid <= 1'b0;
    end else if (branch_valid) begin
      pc       <= branch_target;
      ir_valid <= 1'b0;
    end else if (state == READ) begin
      ir       <= ram_data_out;
      ir_valid <= 1'b1;
    end else if (accept) begin
      pc       <= pc + MAR_SIZE'(1);
      ir_valid <= 1'b0;
    end
  end

  assign ram_address     = pc;
  assign ram_set_address = (state == ADDR);
  assign ram_enable      = (state == READ);
  assign ram_set         = 1'b0;
  assign busy            = (state != IDLE);

endmodule
